// File: rtl/lsu_load_align_pkg.sv
// Shared definitions for the load-alignment block: opcode encodings,
// FSM state encoding, reset polarity and opcode decode helpers.
package lsu_load_align_pkg;

   localparam logic RST_ENABLE = 1'b0;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_LD  = 4'd6;
   localparam logic [3:0] OP_LWU = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // log2 of the access size in bytes (0:1B, 1:2B, 2:4B, 3:8B)
   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU: op_size = 2'd0;
         OP_LH, OP_LHU: op_size = 2'd1;
         OP_LW, OP_LWU: op_size = 2'd2;
         OP_LD:         op_size = 2'd3;
         default:       op_size = 2'd0;
      endcase
   endfunction

   function automatic logic op_signed(input logic [3:0] op);
      op_signed = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
   endfunction

   // LD and LWU only exist when the register file is 64 bits wide
   function automatic logic op_legal(input logic [3:0] op, input logic rv64);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_legal = 1'b1;
         OP_LD, OP_LWU:                       op_legal = rv64;
         default:                             op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align_extract.sv
// Combinational extractor: shifts {hi,lo} right by the byte offset, keeps
// the low 2**size bytes and sign- or zero-extends them to DATA_W.
module lsu_load_extract #(
   parameter int DATA_W = 32,
   parameter int OFF_W  = 2
) (
   input  logic [DATA_W-1:0] i_lo,
   input  logic [DATA_W-1:0] i_hi,
   input  logic [OFF_W-1:0]  i_off,
   input  logic [1:0]        i_size,
   input  logic              i_sign,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] w_low;
   logic [DATA_W-1:0] w_mask;
   logic [6:0]        w_nbits;
   logic              w_msb;

   assign w_low = DATA_W'({i_hi, i_lo} >> {i_off, 3'b000});

   // mask off the bytes above the access size and fill them with the extension bit
   always_comb begin
      w_nbits = 7'd8 << i_size;
      w_mask  = ~({DATA_W{1'b1}} << w_nbits);
      case (i_size)
         2'd0:    w_msb = w_low[7];
         2'd1:    w_msb = w_low[15];
         2'd2:    w_msb = w_low[31];
         default: w_msb = w_low[DATA_W-1];
      endcase
      o_data = (w_low & w_mask) | ({DATA_W{i_sign & w_msb}} & ~w_mask);
   end

endmodule

// File: rtl/lsu_load_align.sv
// Load-data post-processor: accepts a load request, collects one or two
// memory beats, aligns/extends the data and presents it on a valid/ready
// output. Macro LSU_LOAD_ALIGN_MISALIGN_EN enables two-beat merging of
// loads that straddle a beat boundary; without it such loads return err.
module lsu_load_align
   import lsu_load_align_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        lsu_op_i,
   input  logic [OFF_W-1:0]  off_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              beat_valid_i,
   output logic              beat_ready_o,
   input  logic [DATA_W-1:0] beat_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o,
   output logic              out_err_o
);

`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
   localparam logic MISALIGN_EN = 1'b1;
`else
   localparam logic MISALIGN_EN = 1'b0;
`endif

   state_t            r_state, w_next;
   logic              w_rst_act, w_req_hs, w_beat_hs, w_out_hs, w_last_beat;
   logic [1:0]        w_size;
   logic              w_sign, w_split_in, w_err_in;
   logic [OFF_W+1:0]  w_nbytes, w_end;
   logic [1:0]        r_size;
   logic              r_sign, r_split;
   logic [OFF_W-1:0]  r_off;
   logic [TAG_W-1:0]  r_tag;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] w_ext_lo, w_ext_hi, w_ext_data;
   logic [DATA_W-1:0] r_out_data;
   logic [TAG_W-1:0]  r_out_tag;
   logic              r_out_err;

   assign w_rst_act    = (rst == RST_ENABLE);
   assign req_ready_o  = !w_rst_act &&
                         ((r_state == ST_IDLE) || ((r_state == ST_RESP) && out_ready_i));
   assign beat_ready_o = !w_rst_act && ((r_state == ST_BEAT0) || (r_state == ST_BEAT1));
   assign out_valid_o  = (r_state == ST_RESP);
   assign out_data_o   = r_out_data;
   assign out_tag_o    = r_out_tag;
   assign out_err_o    = r_out_err;

   assign w_req_hs  = req_valid_i & req_ready_o;
   assign w_beat_hs = beat_valid_i & beat_ready_o;
   assign w_out_hs  = out_valid_o & out_ready_i;

   // request decode: access size, sign, whether it crosses into the next beat
   assign w_size     = op_size(lsu_op_i);
   assign w_sign     = op_signed(lsu_op_i);
   assign w_nbytes   = (OFF_W+2)'(1) << w_size;
   assign w_end      = {2'b00, off_i} + w_nbytes;
   assign w_split_in = (w_end > (OFF_W+2)'(DATA_W/8));
   assign w_err_in   = !op_legal(lsu_op_i, DATA_W == 64) || (w_split_in && !MISALIGN_EN);

   // the final beat is either the only beat or the high beat of a split load
   assign w_last_beat = w_beat_hs && ((r_state == ST_BEAT1) || !r_split);
   assign w_ext_lo    = (r_state == ST_BEAT1) ? r_lo : beat_data_i;
   assign w_ext_hi    = (r_state == ST_BEAT1) ? beat_data_i : '0;

   lsu_load_extract #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_extract (
      .i_lo   (w_ext_lo),
      .i_hi   (w_ext_hi),
      .i_off  (r_off),
      .i_size (r_size),
      .i_sign (r_sign),
      .o_data (w_ext_data)
   );

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_hs) w_next = w_err_in ? ST_RESP : ST_BEAT0;
         end
         ST_BEAT0: begin
            if (w_beat_hs) w_next = (r_split && MISALIGN_EN) ? ST_BEAT1 : ST_RESP;
         end
         ST_BEAT1: begin
            if (w_beat_hs) w_next = ST_RESP;
         end
         ST_RESP: begin
            if (w_req_hs)      w_next = w_err_in ? ST_RESP : ST_BEAT0;
            else if (w_out_hs) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (w_rst_act) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   // latch the accepted request's decode fields
   always_ff @(posedge clk) begin
      if (w_req_hs) begin
         r_size  <= w_size;
         r_sign  <= w_sign;
         r_split <= w_split_in;
         r_off   <= off_i;
         r_tag   <= tag_i;
      end
   end

   // hold the low beat of a split load until the high beat arrives
   always_ff @(posedge clk) begin
      if (w_beat_hs && (r_state == ST_BEAT0)) r_lo <= beat_data_i;
   end

   // result register: error responses load immediately, good ones on the last beat
   always_ff @(posedge clk) begin
      if (w_rst_act) begin
         r_out_data <= '0;
         r_out_tag  <= '0;
         r_out_err  <= 1'b0;
      end else if (w_req_hs && w_err_in) begin
         r_out_data <= '0;
         r_out_tag  <= tag_i;
         r_out_err  <= 1'b1;
      end else if (w_last_beat) begin
         r_out_data <= w_ext_data;
         r_out_tag  <= r_tag;
         r_out_err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu_load_align.sv
// Self-checking bench for lsu_load_align: one 32-bit and one 64-bit
// instance, directed cases plus randomized loads against a byte-level model.
module tb_lsu_load_align;

`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic [63:0] data;
      logic [1:0]  nbeats;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        req_valid, beat_valid, out_ready;
   logic [3:0]  op;
   logic [2:0]  off;
   logic [4:0]  tag;
   logic [63:0] beat_data;

   logic        rr32, br32, ov32, oe32, rr64, br64, ov64, oe64;
   logic [31:0] od32;
   logic [63:0] od64;
   logic [4:0]  ot32, ot64;

   logic        o_rr, o_br, o_ov, o_err;
   logic [63:0] o_data;
   logic [4:0]  o_tag;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_load_align #(.DATA_W(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid & ~sel), .req_ready_o(rr32),
      .lsu_op_i(op), .off_i(off[1:0]), .tag_i(tag),
      .beat_valid_i(beat_valid & ~sel), .beat_ready_o(br32), .beat_data_i(beat_data[31:0]),
      .out_valid_o(ov32), .out_ready_i(out_ready),
      .out_data_o(od32), .out_tag_o(ot32), .out_err_o(oe32)
   );

   lsu_load_align #(.DATA_W(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid & sel), .req_ready_o(rr64),
      .lsu_op_i(op), .off_i(off), .tag_i(tag),
      .beat_valid_i(beat_valid & sel), .beat_ready_o(br64), .beat_data_i(beat_data),
      .out_valid_o(ov64), .out_ready_i(out_ready),
      .out_data_o(od64), .out_tag_o(ot64), .out_err_o(oe64)
   );

   assign o_rr   = sel ? rr64 : rr32;
   assign o_br   = sel ? br64 : br32;
   assign o_ov   = sel ? ov64 : ov32;
   assign o_err  = sel ? oe64 : oe32;
   assign o_data = sel ? od64 : {32'h0, od32};
   assign o_tag  = sel ? ot64 : ot32;

   // Byte-level reference: pick bytes off..off+n-1 of the lo:hi byte stream.
   function automatic exp_t model(input int dw, input logic [3:0] o, input int of,
                                  input logic [63:0] lo, input logic [63:0] hi);
      exp_t e;
      int nb, idx;
      bit sg, legal, split;
      logic [63:0] r;
      nb = 1; sg = 0; legal = 1; e = '0;
      case (o)
         4'd1: begin nb = 1; sg = 1; end
         4'd2: begin nb = 2; sg = 1; end
         4'd3: begin nb = 4; sg = 1; end
         4'd4: nb = 1;
         4'd5: nb = 2;
         4'd6: begin nb = 8; legal = (dw == 64); end
         4'd7: begin nb = 4; legal = (dw == 64); end
         default: legal = 0;
      endcase
      if (!legal) begin e.err = 1'b1; return e; end
      split = (of + nb) > dw / 8;
      if (split && !MIS) begin e.err = 1'b1; return e; end
      e.nbeats = split ? 2'd2 : 2'd1;
      r = '0;
      for (int i = 0; i < nb; i++) begin
         idx = of + i;
         if (idx < dw / 8) r[i*8 +: 8] = lo[idx*8 +: 8];
         else              r[i*8 +: 8] = hi[(idx - dw/8)*8 +: 8];
      end
      if (sg && r[nb*8-1]) for (int i = nb*8; i < 64; i++) r[i] = 1'b1;
      if (dw == 32) r[63:32] = '0;
      e.data = r;
      return e;
   endfunction

   // Drive one full load transaction on the selected instance and check it.
   task automatic run_txn(input string nm, input logic s, input logic [3:0] o, input int of,
                          input logic [4:0] tg, input logic [63:0] lo, input logic [63:0] hi,
                          input exp_t ex, input int stall, input int gap);
      sel = s;
      #1;
      n_cmp++; if (o_rr !== 1'b1) begin n_bad++; $display("FAIL %s.req_ready got %b exp 1", nm, o_rr); end
      req_valid = 1'b1; op = o; off = 3'(of); tag = tg;
      @(negedge clk);
      req_valid = 1'b0; op = 4'($urandom); off = 3'($urandom); tag = 5'($urandom);
      if (ex.nbeats == 2'd0) begin
         n_cmp++; if (o_br !== 1'b0) begin n_bad++; $display("FAIL %s.beat_ready got %b exp 0", nm, o_br); end
      end
      for (int b = 0; b < int'(ex.nbeats); b++) begin
         for (int g = 0; g < gap; g++) begin
            n_cmp++; if (o_ov !== 1'b0 || o_br !== 1'b1) begin n_bad++; $display("FAIL %s.wait_beat got ov=%b br=%b exp ov=0 br=1", nm, o_ov, o_br); end
            @(negedge clk);
         end
         n_cmp++; if (o_br !== 1'b1) begin n_bad++; $display("FAIL %s.beat%0d_ready got %b exp 1", nm, b, o_br); end
         beat_valid = 1'b1; beat_data = (b == 0) ? lo : hi;
         @(negedge clk);
         beat_valid = 1'b0; beat_data = {$urandom, $urandom};
      end
      n_cmp++; if (o_ov !== 1'b1) begin n_bad++; $display("FAIL %s.out_valid got %b exp 1", nm, o_ov); end
      n_cmp++; if (o_data !== ex.data) begin n_bad++; $display("FAIL %s.data got %h exp %h", nm, o_data, ex.data); end
      n_cmp++; if (o_err !== ex.err) begin n_bad++; $display("FAIL %s.err got %b exp %b", nm, o_err, ex.err); end
      n_cmp++; if (o_tag !== tg) begin n_bad++; $display("FAIL %s.tag got %h exp %h", nm, o_tag, tg); end
      for (int k = 0; k < stall; k++) begin
         out_ready = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (o_ov !== 1'b1 || o_data !== ex.data || o_tag !== tg || o_rr !== 1'b0 || o_br !== 1'b0) begin
            n_bad++;
            $display("FAIL %s.hold got ov=%b d=%h t=%h rr=%b br=%b exp ov=1 d=%h t=%h rr=0 br=0",
                     nm, o_ov, o_data, o_tag, o_rr, o_br, ex.data, tg);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (o_ov !== 1'b0 || o_rr !== 1'b1) begin n_bad++; $display("FAIL %s.drain got ov=%b rr=%b exp ov=0 rr=1", nm, o_ov, o_rr); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_cmp++;
         if (o_rr !== 1'b0 || o_br !== 1'b0 || o_ov !== 1'b0 || o_data !== 64'h0 || o_tag !== 5'h0 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset%0d got rr=%b br=%b ov=%b d=%h t=%h e=%b exp all 0", s, o_rr, o_br, o_ov, o_data, o_tag, o_err);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_cmp++; if (o_rr !== 1'b1) begin n_bad++; $display("FAIL reset_release%0d.req_ready got %b exp 1", s, o_rr); end
      end
   endtask

   task automatic test_directed();
      exp_t e;
      e = '{err: 1'b0, data: 64'h0000_0000_FFFF_FF80, nbeats: 2'd1};
      run_txn("lb_off3", 1'b0, 4'd1, 3, 5'h11, 64'h80AA_BBCC, 64'h0, e, 0, 0);
      e = '{err: 1'b0, data: 64'h0000_0000_0000_BEEF, nbeats: 2'd1};
      run_txn("lhu_stall", 1'b0, 4'd5, 2, 5'h0A, 64'hBEEF_1234, 64'h0, e, 3, 0);
      e = '{err: 1'b0, data: 64'h0000_0000_8765_4321, nbeats: 2'd1};
      run_txn("lwu64", 1'b1, 4'd7, 4, 5'h1F, 64'h8765_4321_0000_0000, 64'h0, e, 0, 1);
      e = '{err: 1'b0, data: 64'h0123_4567_89AB_CDEF, nbeats: 2'd1};
      run_txn("ld64", 1'b1, 4'd6, 0, 5'h03, 64'h0123_4567_89AB_CDEF, 64'h0, e, 1, 0);
   endtask

   task automatic test_misalign();
      exp_t e;
      if (MIS) e = '{err: 1'b0, data: 64'h0000_0000_7788_1122, nbeats: 2'd2};
      else     e = '{err: 1'b1, data: 64'h0, nbeats: 2'd0};
      run_txn("lw_split", 1'b0, 4'd3, 2, 5'h15, 64'h1122_3344, 64'h5566_7788, e, 1, 1);
   endtask

   task automatic test_illegal();
      exp_t e;
      e = '{err: 1'b1, data: 64'h0, nbeats: 2'd0};
      run_txn("op0_32", 1'b0, 4'd0, 0, 5'h01, 64'h0, 64'h0, e, 0, 0);
      run_txn("op9_32", 1'b0, 4'd9, 1, 5'h02, 64'h0, 64'h0, e, 1, 0);
      run_txn("ld_32", 1'b0, 4'd6, 0, 5'h04, 64'h0, 64'h0, e, 0, 0);
      run_txn("lwu_32", 1'b0, 4'd7, 0, 5'h08, 64'h0, 64'h0, e, 0, 0);
      run_txn("op15_64", 1'b1, 4'd15, 0, 5'h10, 64'h0, 64'h0, e, 0, 0);
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      #1;
      req_valid = 1'b1; op = 4'd3; off = 3'd0; tag = 5'h07;
      @(negedge clk);
      req_valid = 1'b0; beat_valid = 1'b1; beat_data = 64'hCAFE_0001;
      @(negedge clk);
      beat_valid = 1'b0;
      n_cmp++; if (o_ov !== 1'b1 || o_data !== 64'hCAFE_0001) begin n_bad++; $display("FAIL b2b.first got ov=%b d=%h exp ov=1 d=00000000cafe0001", o_ov, o_data); end
      out_ready = 1'b1; req_valid = 1'b1; op = 4'd4; off = 3'd1; tag = 5'h09;
      #1;
      n_cmp++; if (o_rr !== 1'b1) begin n_bad++; $display("FAIL b2b.req_ready got %b exp 1", o_rr); end
      @(negedge clk);
      req_valid = 1'b0; out_ready = 1'b0;
      n_cmp++; if (o_ov !== 1'b0 || o_br !== 1'b1) begin n_bad++; $display("FAIL b2b.no_bubble got ov=%b br=%b exp ov=0 br=1", o_ov, o_br); end
      beat_valid = 1'b1; beat_data = 64'h1234_5678;
      @(negedge clk);
      beat_valid = 1'b0;
      n_cmp++; if (o_ov !== 1'b1 || o_data !== 64'h56 || o_tag !== 5'h09) begin n_bad++; $display("FAIL b2b.second got ov=%b d=%h t=%h exp ov=1 d=56 t=09", o_ov, o_data, o_tag); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (o_ov !== 1'b0 || o_rr !== 1'b1) begin n_bad++; $display("FAIL b2b.drain got ov=%b rr=%b exp ov=0 rr=1", o_ov, o_rr); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      sel = 1'b0;
      #1;
      req_valid = 1'b1; op = 4'd3; off = MIS ? 3'd2 : 3'd0; tag = 5'h1E;
      @(negedge clk);
      req_valid = 1'b0;
      if (MIS) begin
         beat_valid = 1'b1; beat_data = 64'hAAAA_BBBB;
         @(negedge clk);
         beat_valid = 1'b0;
         n_cmp++; if (o_br !== 1'b1 || o_ov !== 1'b0) begin n_bad++; $display("FAIL rmid.in_beat1 got br=%b ov=%b exp br=1 ov=0", o_br, o_ov); end
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_rr !== 1'b0 || o_br !== 1'b0 || o_ov !== 1'b0 || o_data !== 64'h0 || o_tag !== 5'h0 || o_err !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid.reset got rr=%b br=%b ov=%b d=%h t=%h e=%b exp all 0", o_rr, o_br, o_ov, o_data, o_tag, o_err);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (o_rr !== 1'b1 || o_br !== 1'b0) begin n_bad++; $display("FAIL rmid.release got rr=%b br=%b exp rr=1 br=0", o_rr, o_br); end
      e = model(32, 4'd2, 0, 64'h0000_8001, 64'h0);
      run_txn("rmid.after", 1'b0, 4'd2, 0, 5'h05, 64'h0000_8001, 64'h0, e, 0, 0);
   endtask

   task automatic test_random();
      exp_t e;
      logic s;
      logic [3:0] o;
      int of, dw, r;
      logic [63:0] lo, hi;
      for (int n = 0; n < 80; n++) begin
         s  = 1'($urandom);
         dw = s ? 64 : 32;
         r  = $urandom_range(0, 9);
         o  = (r < 8) ? 4'(r) : 4'($urandom_range(8, 15));
         of = $urandom_range(0, dw/8 - 1);
         lo = s ? {$urandom, $urandom} : {32'h0, $urandom};
         hi = s ? {$urandom, $urandom} : {32'h0, $urandom};
         e  = model(dw, o, of, lo, hi);
         run_txn($sformatf("rnd%0d", n), s, o, of, 5'($urandom), lo, hi, e,
                 $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; req_valid = 1'b0; beat_valid = 1'b0; out_ready = 1'b0;
      op = 4'd0; off = 3'd0; tag = 5'd0; beat_data = 64'd0;
      test_reset();
      test_directed();
      test_misalign();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_load_align.md
Name: lsu_load_align

Overview:
- Sequential load-data post-processor in the EXU/LSU path, between the data-SRAM read port and register writeback.
- Latches a load request (opcode, byte offset, tag), then collects one or two raw memory beats.
- Shifts, merges, sign- or zero-extends the data and holds the result in an output register behind a valid/ready handshake.
- Generalises single-cycle word-only post-processing: width parametric (32/64), RV64 loads, two-beat misaligned merge, back-to-back throughput.

Parameters:
- DATA_W, 32, memory beat and register width; legal values 32 or 64.
- TAG_W, 5, width of the pass-through destination tag (rd index).
- OFF_W, $clog2(DATA_W/8), byte-offset width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when rst==1'b0, sampled on posedge clk)
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  request accepted when valid&ready
- lsu_op_i  in  4  load opcode (package encodings)
- off_i  in  OFF_W  byte offset of load address within beat
- tag_i  in  TAG_W  destination tag
- beat_valid_i  in  1  memory beat valid
- beat_ready_o  out  1  block consumes beat when valid&ready
- beat_data_i  in  DATA_W  raw aligned memory beat
- out_valid_o  out  1  result valid
- out_ready_i  in  1  writeback accepts result
- out_data_o  out  DATA_W  aligned, extended load data
- out_tag_o  out  TAG_W  tag of the result
- out_err_o  out  1  illegal opcode or unsupported misalignment

Behaviour:
- Reset: state=IDLE; req_ready_o=0 during reset, 1 the first cycle after; beat_ready_o=0; out_valid_o=0; out_data_o=0; out_tag_o=0; out_err_o=0.
- Reset mid-operation aborts any pending request; collected beats are discarded.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready_o=1. On handshake, latch op/off/tag, compute size (1/2/4/8 bytes) and split = (off+size > DATA_W/8). Go to BEAT0.
- Illegal request: undefined opcode, or LD/LWU with DATA_W=32. Skip beats, go to RESP with out_err_o=1 and out_data_o=0.
- BEAT0: beat_ready_o=1. On beat handshake, store the low beat. If split, go to BEAT1; otherwise go to RESP.
- BEAT1: beat_ready_o=1. On handshake, store the high beat and go to RESP.
- Beats arriving in IDLE or RESP are not accepted (beat_ready_o=0).
- Data formation: window = {hi_beat, lo_beat} >> (off*8); take low size bytes. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD takes all 64 bits. If not split, hi_beat is treated as 0.
- Latency: out_valid_o rises the cycle after the last beat handshake, or the cycle after request acceptance when illegal.
- RESP: out_valid_o=1. out_data_o, out_tag_o and out_err_o are stable until out_ready_i.
- In RESP, req_ready_o = out_ready_i. Simultaneous output and request handshakes go straight to BEAT0 with no IDLE bubble. Output handshake with no new request goes to IDLE and clears out_valid_o.

Optional Feature:
- Macro LSU_LOAD_ALIGN_MISALIGN_EN.
- Defined: split loads fetch two beats and merge them as above.
- Undefined: BEAT1 is never entered. A split request goes to RESP immediately after acceptance with out_err_o=1, out_data_o=0, and consumes no beats.
- Aligned behaviour is identical in both builds.

Decomposition:
- Shared package: opcode constants (LB=1, LH=2, LW=3, LBU=4, LHU=5, LD=6, LWU=7; 0 and 8-15 illegal), state encodings, RST_ENABLE=1'b0.
- One natural sub-module, lsu_load_extract: combinational shift/select/extend of {hi,lo} by off, size and sign.
- The FSM and registers stay in lsu_load_align.

Test Plan:
- DATA_W=32, LB, off=3, beat 0x80AA_BBCC -> out_data 0xFFFF_FF80, err=0, out_valid one cycle after beat.
- DATA_W=32, LHU, off=2, beat 0xBEEF_1234 -> 0x0000_BEEF. Hold out_ready_i=0 for 3 cycles: data, tag and valid stable, req_ready_o=0.
- DATA_W=64, LWU, off=4, beat 0x8765_4321_0000_0000 -> 0x0000_0000_8765_4321. LD, off=0 -> full beat.
- MISALIGN_EN: DATA_W=32, LW, off=2, beats 0x1122_3344 then 0x5566_7788 -> 0x7788_1122.
- Same stimulus without the macro -> err=1, data 0, beat_ready_o never asserted.
- Back-to-back: second request presented with out_ready_i=1 in RESP -> accepted that cycle, no IDLE cycle. Reset asserted in BEAT1 -> next cycle all outputs 0, state IDLE, req_ready_o=1 after release.
